// File: rtl/tlu_event_writer_if.sv
// Write-side bus between the event writer and the downstream readout FIFO.
//   WR_EN   : write strobe, a word moves on every rising edge with WR_EN=1
//   WR_DATA : 32-bit record word
//   WR_FULL : downstream FIFO full, holds the writer off
// master = event writer, slave = FIFO.
interface tlu_event_writer_if;
   logic        WR_EN;
   logic [31:0] WR_DATA;
   logic        WR_FULL;

   modport master (output WR_EN, output WR_DATA, input WR_FULL);
   modport slave  (input WR_EN, input WR_DATA, output WR_FULL);
endinterface

// File: rtl/tlu_event_writer.sv
// Trigger-event record writer for the TLU readout FIFO.
// Each accepted trigger snapshots {TIME_STAMP, TRIG_ID, LE_DISTANCE} into a
// 2**QUEUE_AW deep pending queue.  A write FSM drains the queue as 4-word
// records and stalls while the FIFO is full.  Triggers that find the queue
// full are dropped and counted in a saturating counter.
// Ports:
//   SYS_CLK, SYS_RST : clock, asynchronous active-high reset
//   ENABLE, TRIG     : trigger accept enable, single-cycle trigger pulse
//   TIME_STAMP, TRIG_ID, LE_DISTANCE : event data sampled with TRIG
//   wr               : write bus (WR_EN / WR_DATA out, WR_FULL in)
//   QUEUE_COUNT      : pending records, not counting the one being written
//   LOST_CNT         : dropped-trigger counter, saturates at 8'hFF
//   BUSY             : record in flight or queue non-empty
module tlu_event_writer #(
   parameter int QUEUE_AW = 2
) (
   input  logic                SYS_CLK,
   input  logic                SYS_RST,
   input  logic                ENABLE,
   input  logic                TRIG,
   input  logic [63:0]         TIME_STAMP,
   input  logic [31:0]         TRIG_ID,
   input  logic [7:0]          LE_DISTANCE,
   tlu_event_writer_if.master  wr,
   output logic [QUEUE_AW:0]   QUEUE_COUNT,
   output logic [7:0]          LOST_CNT,
   output logic                BUSY
);

   localparam int DEPTH = 1 << QUEUE_AW;

   typedef struct packed {
      logic [63:0] ts;
      logic [31:0] id;
      logic [7:0]  le;
   } evt_t;

   typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

   state_t              state_q, state_d;
   evt_t                mem_q [DEPTH];
   evt_t                rec_q;
   logic [QUEUE_AW:0]   wr_ptr_q, rd_ptr_q;
   logic [QUEUE_AW:0]   count;
   logic [7:0]          lost_q;
   logic                full, empty, trig_v, push, pop, drop, wr_en;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == (QUEUE_AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = (state_q != IDLE) && !wr.WR_FULL;

   // A pop on the same edge frees a slot, so a trigger into a full queue
   // is still accepted when the FSM is taking the head entry.
   assign trig_v = TRIG && ENABLE;
   assign push   = trig_v && (!full || pop);
   assign drop   = trig_v && full && !pop;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!empty) begin state_d = W0; pop = 1'b1; end
         W0:   if (wr_en) state_d = W1;
         W1:   if (wr_en) state_d = W2;
         W2:   if (wr_en) state_d = W3;
         W3:   if (wr_en) begin
                  if (!empty) begin state_d = W0; pop = 1'b1; end
                  else state_d = IDLE;
               end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rec_q    <= '0;
         lost_q   <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + (QUEUE_AW+1)'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (QUEUE_AW+1)'(1);
            rec_q    <= mem_q[rd_ptr_q[QUEUE_AW-1:0]];
         end
         if (drop && lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.  On a
   // push/pop collision the slot is read before it is overwritten.
   always_ff @(posedge SYS_CLK) begin
      if (push) mem_q[wr_ptr_q[QUEUE_AW-1:0]] <= '{ts: TIME_STAMP, id: TRIG_ID, le: LE_DISTANCE};
   end

   always_comb begin
      wr.WR_DATA = 32'h0;
      case (state_q)
         W0: wr.WR_DATA = {4'h8, rec_q.id[27:0]};
         W1: wr.WR_DATA = {4'h9, rec_q.le, rec_q.ts[63:44]};
         W2: wr.WR_DATA = {4'hA, rec_q.ts[43:16]};
         W3: wr.WR_DATA = {4'hB, 12'h000, rec_q.ts[15:0]};
         default: wr.WR_DATA = 32'h0;
      endcase
   end

   assign wr.WR_EN     = wr_en;
   assign QUEUE_COUNT  = count;
   assign LOST_CNT     = lost_q;
   assign BUSY         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_tlu_event_writer.sv
module tb_tlu_event_writer;
   logic        SYS_CLK = 1'b0;
   logic        SYS_RST = 1'b1;
   logic        ENABLE = 1'b1;
   logic        TRIG = 1'b0;
   logic [63:0] TIME_STAMP = '0;
   logic [31:0] TRIG_ID = '0;
   logic [7:0]  LE_DISTANCE = '0;
   logic [2:0]  QUEUE_COUNT;
   logic [7:0]  LOST_CNT;
   logic        BUSY;

   tlu_event_writer_if wif ();

   tlu_event_writer #(.QUEUE_AW(2)) dut (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE), .TRIG(TRIG),
      .TIME_STAMP(TIME_STAMP), .TRIG_ID(TRIG_ID), .LE_DISTANCE(LE_DISTANCE),
      .wr(wif.master), .QUEUE_COUNT(QUEUE_COUNT), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] sb [$];
   int          run = 0;
   int          max_run = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Record word k of an event, straight from the record layout.
   function automatic logic [31:0] fmt(input logic [63:0] ts, input logic [31:0] id,
                                       input logic [7:0] le, input int k);
      case (k)
         0:       return {4'h8, id[27:0]};
         1:       return {4'h9, le, ts[63:44]};
         2:       return {4'hA, ts[43:16]};
         default: return {4'hB, 12'h000, ts[15:0]};
      endcase
   endfunction

   // Every word the DUT hands over must be the next expected one.
   always @(negedge SYS_CLK) begin
      if (wif.WR_EN === 1'b1) begin
         if (sb.size() == 0) chk("unexp_word", wif.WR_DATA, 64'h0);
         else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("word", wif.WR_DATA, e);
         end
         run++;
         if (run > max_run) max_run = run;
      end else run = 0;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge SYS_CLK);
      #1;
   endtask

   // Trigger sampled on the next rising edge; returns 1 time unit after it.
   task automatic pulse(input logic [63:0] ts, input logic [31:0] id,
                        input logic [7:0] le, input bit acc);
      TRIG = 1'b1; TIME_STAMP = ts; TRIG_ID = id; LE_DISTANCE = le;
      if (acc) for (int k = 0; k < 4; k++) sb.push_back(fmt(ts, id, le, k));
      tick(1);
      TRIG = 1'b0;
   endtask

   task automatic rnd_pulse(input int idx, input bit acc);
      pulse({$urandom, $urandom}, 32'h0100_0000 + 32'(idx), 8'($urandom), acc);
   endtask

   task automatic drain(input int n, input string tag);
      tick(n);
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   task automatic do_reset();
      SYS_RST = 1'b1; TRIG = 1'b0; ENABLE = 1'b1; wif.WR_FULL = 1'b0;
      tick(2);
      sb.delete();
      SYS_RST = 1'b0;
      tick(1);
   endtask

   initial begin
      wif.WR_FULL = 1'b0;
      #2;
      chk("rst_wr_en", wif.WR_EN, 0);
      chk("rst_wr_data", wif.WR_DATA, 0);
      chk("rst_qcount", QUEUE_COUNT, 0);
      chk("rst_lost", LOST_CNT, 0);
      chk("rst_busy", BUSY, 0);
      do_reset();

      // Single trigger with literal record words.
      sb.push_back(32'h8000_0005); sb.push_back(32'h9030_1234);
      sb.push_back(32'hA567_89AB); sb.push_back(32'hB000_CDEF);
      pulse(64'h0123_4567_89AB_CDEF, 32'h0000_0005, 8'h03, 1'b0);
      chk("lat_not_yet", wif.WR_EN, 0);
      tick(1);
      chk("lat_w0", wif.WR_EN, 1);
      chk("lat_busy", BUSY, 1);
      tick(4);
      chk("single_busy_fall", BUSY, 0);
      chk("single_done", 64'(sb.size()), 0);

      // Backpressure while W1 is presented.
      begin
         logic [63:0] ts; logic [31:0] id; logic [7:0] le;
         ts = 64'hFEDC_BA98_7654_3210; id = 32'h0ABC_DEF1; le = 8'h5A;
         pulse(ts, id, le, 1'b1);
         tick(2);
         wif.WR_FULL = 1'b1;
         #1;
         chk("bp_wr_en", wif.WR_EN, 0);
         chk("bp_data", wif.WR_DATA, fmt(ts, id, le, 1));
         tick(10);
         chk("bp_wr_en_end", wif.WR_EN, 0);
         chk("bp_data_end", wif.WR_DATA, fmt(ts, id, le, 1));
         wif.WR_FULL = 1'b0;
         drain(8, "bp_drain");
      end

      // Overflow: 7 back-to-back triggers into a stalled writer.
      wif.WR_FULL = 1'b1;
      for (int i = 0; i < 7; i++) rnd_pulse(i, i < 5);
      chk("ovf_qcount", QUEUE_COUNT, 4);
      chk("ovf_lost", LOST_CNT, 2);
      wif.WR_FULL = 1'b0;
      drain(30, "ovf_drain");

      // Push/pop collision on the W3 handshake edge while full.
      do_reset();
      wif.WR_FULL = 1'b1;
      for (int i = 0; i < 6; i++) rnd_pulse(i, i < 5);
      chk("col_lost_pre", LOST_CNT, 1);
      wif.WR_FULL = 1'b0;
      tick(3);
      chk("col_full_pre", QUEUE_COUNT, 4);
      rnd_pulse(99, 1'b1);
      chk("col_lost", LOST_CNT, 1);
      chk("col_qcount", QUEUE_COUNT, 4);
      drain(30, "col_drain");

      // Saturation of the lost counter.
      wif.WR_FULL = 1'b1;
      for (int i = 0; i < 305; i++) rnd_pulse(i, i < 5);
      chk("sat_lost", LOST_CNT, 255);
      wif.WR_FULL = 1'b0;
      drain(30, "sat_drain");

      // ENABLE low ignores triggers; dropping ENABLE does not stop draining.
      do_reset();
      ENABLE = 1'b0;
      rnd_pulse(0, 1'b0);
      tick(8);
      chk("en_lost", LOST_CNT, 0);
      chk("en_busy", BUSY, 0);
      ENABLE = 1'b1;
      rnd_pulse(1, 1'b1);
      ENABLE = 1'b0;
      drain(10, "en_drain");
      ENABLE = 1'b1;

      // Asynchronous reset while W2 is presented with two records queued.
      for (int i = 0; i < 3; i++) rnd_pulse(i, 1'b1);
      tick(1);
      chk("mid_qcount_pre", QUEUE_COUNT, 2);
      chk("mid_wr_en_pre", wif.WR_EN, 1);
      SYS_RST = 1'b1;
      #1;
      chk("mid_wr_en", wif.WR_EN, 0);
      chk("mid_qcount", QUEUE_COUNT, 0);
      chk("mid_busy", BUSY, 0);
      sb.delete();
      tick(1);
      SYS_RST = 1'b0;
      drain(12, "mid_nowrite");
      chk("mid_busy_after", BUSY, 0);

      // Back-to-back: one trigger every 4 cycles.
      do_reset();
      max_run = 0;
      for (int i = 0; i < 8; i++) begin
         rnd_pulse(i, 1'b1);
         tick(3);
      end
      drain(10, "b2b_drain");
      chk("b2b_run", 64'(max_run), 32);
      chk("b2b_lost", LOST_CNT, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
